// File: rtl/mdu_pkg.sv
// Shared constants for the MIPS multiply/divide unit: operand width,
// iteration count, opcode and FSM state encodings.
package mdu_pkg;
  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS HI/LO unit: 32-step shift-add multiply and restoring divide
// over operand magnitudes, with the sign fix applied in a final FIX cycle.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     operandA,
  input  logic [WIDTH-1:0]     operandB,
  input  logic                 writeHi,
  input  logic                 writeLo,
  input  logic [WIDTH-1:0]     writeData,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic                 busy,
  output logic                 done
);

  function automatic logic [WIDTH-1:0] neg32(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg64(input logic [2*WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return s ? neg32(v) : v;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    // Multiply: add multiplicand into the upper half, shift the whole product right.
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    // Divide: partial remainder lives in acc_q[WIDTH:0], dividend shifts out of a_q.
    shifted = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, b_q};
    prod    = (sa_q ^ sb_q) ? neg64(acc_q) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          sa_d    = ~op[0] & operandA[WIDTH-1];
          sb_d    = ~op[0] & operandB[WIDTH-1];
          a_d     = mag(operandA, sa_d);
          b_d     = mag(operandB, sb_d);
          bz_d    = (operandB == '0);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end else begin
          if (writeHi) hi_d = writeData;
          if (writeLo) lo_d = writeData;
        end
      end
      S_CALC: begin
        if (!op_q[1]) begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end else if (!diff[WIDTH+1]) begin
          acc_d = {{(WIDTH-1){1'b0}}, diff[WIDTH:0]};
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {{(WIDTH-1){1'b0}}, shifted};
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q[1]) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          // Remainder rule also restores the raw dividend on divide-by-zero.
          hi_d = sa_q ? neg32(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
          lo_d = bz_q ? '1 : ((sa_q ^ sb_q) ? neg32(a_q) : a_q);
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA, operandB, writeData;
  logic        writeHi, writeLo;
  logic [31:0] hi, lo;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  mult_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB),
    .writeHi(writeHi), .writeLo(writeLo), .writeData(writeData),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: hi=%h lo=%h with nothing expected", hi, lo);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        if ({hi, lo} !== e) begin
          bad++;
          $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Issue one op at the coming edge; check hold of old HI/LO, busy length and done.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] ph, pl;
    int n;
    ph = hi; pl = lo;
    sb_q.push_back({eh, el});
    start = 1'b1; op = o; operandA = a; operandB = b;
    @(negedge clock);
    start = 1'b0; writeHi = 1'b0; writeLo = 1'b0;
    check({name, "_hold"}, {hi, lo}, {ph, pl});
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy) n++;
      @(negedge clock);
    end
    check({name, "_busy_cycles"}, 64'(n), 64'd33);
    check({name, "_busy_low_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; operandA = '0; operandB = '0;
    writeHi = 1'b0; writeLo = 1'b0; writeData = '0;
    repeat (2) @(negedge clock);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;

    writeLo = 1'b1; writeData = 32'h12345678;
    @(negedge clock);
    writeLo = 1'b0;
    check("mtlo", {hi, lo}, {32'h0, 32'h12345678});

    // Consecutive calls exercise back-to-back starts with no dead cycle.
    run_op("mult_neg",   2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("div_neg",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",       2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF);
    run_op("divu_zero",  2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    run_op("div_zero",   2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Busy interlock: a second start and MTHI mid-operation are ignored.
    sb_q.push_back({32'd0, 32'd30});
    start = 1'b1; op = 2'b00; operandA = 32'd5; operandB = 32'd6;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    start = 1'b1; op = 2'b11; operandA = 32'd1; operandB = 32'd1;
    writeHi = 1'b1; writeData = 32'hDEADBEEF;
    @(negedge clock);
    start = 1'b0; writeHi = 1'b0;
    check("interlock_hold", {hi, lo}, {32'h0, 32'h80000000});
    check("interlock_busy", {63'd0, busy}, 64'd1);
    begin
      int n = 0;
      while (done !== 1'b1 && n < 100) begin n++; @(negedge clock); end
      check("interlock_done_seen", {63'd0, done}, 64'd1);
    end
    repeat (40) @(negedge clock);

    writeHi = 1'b1; writeLo = 1'b1; writeData = 32'hA5A5A5A5;
    @(negedge clock);
    writeHi = 1'b0; writeLo = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'hA5A5A5A5, 32'hA5A5A5A5});

    // Start wins over a simultaneous MTHI/MTLO.
    writeHi = 1'b1; writeLo = 1'b1; writeData = 32'h0000FFFF;
    run_op("start_wins", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

    // Reset mid-operation aborts without a done pulse.
    start = 1'b1; op = 2'b11; operandA = 32'd100; operandB = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("abort_idle", {62'd0, busy, done}, 64'd0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
